// File: rtl/acc_drain.sv
// acc_drain -- snapshot-and-stream drain for a MAC accumulator array.
//
// On a capture request in IDLE, every PE accumulator (20-bit signed) and the
// INT4/INT8 layout select are latched. The snapshot is then streamed out one
// word per valid/ready handshake, and the MAC array is told to clear with a
// single-cycle pulse in the first output cycle.
//
//   INT8 layout : NUM_PE words, PE 0 first, each word passed through as is.
//   INT4 layout : 2*NUM_PE words; per PE the low 10-bit half [9:0] comes
//                 first, then the high half [19:10], each sign-extended.
//
// Optional feature (compile-time macro):
//   ACC_DRAIN_RELU_EN  defined   -> negative output words are clamped to 0.
//                      undefined -> words are emitted as signed values.
//
// Parameters:
//   NUM_PE       number of accumulators per snapshot (1..16)
//
// Ports:
//   clock        single clock, rising edge
//   reset        synchronous, active-low reset
//   capture      snapshot request (acted on only in IDLE)
//   i_int4_mode  layout select sampled with capture (0 = INT8, 1 = INT4)
//   acc_in       packed accumulators, PE k at bits [20k+19:20k]
//   clear_acc    one-cycle pulse clearing the MAC array after a snapshot
//   busy         snapshot held / streaming
//   o_valid      output word valid
//   i_ready      downstream ready
//   o_data       signed output word
//   o_index      index of the current word within the snapshot
//   o_last       final word of the snapshot
//   dropped      sticky: a capture arrived while busy and was ignored

module acc_drain #(
  parameter int NUM_PE = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   capture,
  input  logic                   i_int4_mode,
  input  logic [NUM_PE*20-1:0]   acc_in,
  output logic                   clear_acc,
  output logic                   busy,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic [19:0]            o_data,
  output logic [4:0]             o_index,
  output logic                   o_last,
  output logic                   dropped
);

  localparam logic [4:0] LAST_INT8 = 5'(NUM_PE - 1);
  localparam logic [4:0] LAST_INT4 = 5'(2 * NUM_PE - 1);

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  state_t      state;
  state_t      state_n;

  logic [4:0]  idx;
  logic [4:0]  idx_n;
  logic        int4_q;
  logic        clear_q;
  logic        dropped_q;
  logic [19:0] snap [NUM_PE];

  logic        load;
  logic        drop_set;
  logic        is_last;
  logic [4:0]  last_idx;

  logic [4:0]  pe_sel;
  logic        hi_half;
  logic [19:0] pe_word;
  logic [19:0] sel_word;
  logic [19:0] out_word;

  // ---------------------------------------------------------------------------
  // Sequential state: FSM register, word index, snapshot, flags
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= IDLE;
      idx       <= '0;
      int4_q    <= 1'b0;
      clear_q   <= 1'b0;
      dropped_q <= 1'b0;
      for (int unsigned k = 0; k < NUM_PE; k++) begin
        snap[k] <= '0;
      end
    end else begin
      state   <= state_n;
      idx     <= idx_n;
      // The clear pulse lands in the first STREAM cycle: it is simply the
      // load strobe delayed by one clock.
      clear_q <= load;
      if (load) begin
        int4_q <= i_int4_mode;
        for (int unsigned k = 0; k < NUM_PE; k++) begin
          snap[k] <= acc_in[20*k +: 20];
        end
      end
      if (drop_set) begin
        dropped_q <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  assign last_idx = int4_q ? LAST_INT4 : LAST_INT8;
  assign is_last  = (idx == last_idx);

  always_comb begin
    state_n  = state;
    idx_n    = idx;
    load     = 1'b0;
    drop_set = 1'b0;

    unique case (state)
      IDLE: begin
        if (capture) begin
          load    = 1'b1;
          idx_n   = '0;
          state_n = STREAM;
        end
      end

      STREAM: begin
        // Any capture while streaming is ignored, including the cycle of
        // the final handshake; the stream itself is unaffected.
        if (capture) begin
          drop_set = 1'b1;
        end
        if (i_ready) begin
          if (is_last) begin
            idx_n   = '0;
            state_n = IDLE;
          end else begin
            idx_n   = idx + 5'd1;
          end
        end
      end

      default: begin
        state_n = IDLE;
        idx_n   = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Word selection
  // ---------------------------------------------------------------------------
  // INT4 uses two output words per PE, so the PE number is idx/2 and idx[0]
  // picks the half; INT8 maps index straight to PE.
  assign pe_sel  = int4_q ? {1'b0, idx[4:1]} : idx;
  assign hi_half = int4_q & idx[0];

  always_comb begin
    pe_word = '0;
    for (int unsigned k = 0; k < NUM_PE; k++) begin
      if (pe_sel == 5'(k)) begin
        pe_word = snap[k];
      end
    end
  end

  always_comb begin
    sel_word = pe_word;
    if (int4_q) begin
      if (hi_half) begin
        sel_word = {{10{pe_word[19]}}, pe_word[19:10]};
      end else begin
        sel_word = {{10{pe_word[9]}}, pe_word[9:0]};
      end
    end
  end

`ifdef ACC_DRAIN_RELU_EN
  assign out_word = sel_word[19] ? '0 : sel_word;
`else
  assign out_word = sel_word;
`endif

  // ---------------------------------------------------------------------------
  // Outputs (all forced to zero in IDLE)
  // ---------------------------------------------------------------------------
  assign busy      = (state == STREAM);
  assign o_valid   = (state == STREAM);
  assign clear_acc = clear_q;
  assign dropped   = dropped_q;
  assign o_data    = (state == STREAM) ? out_word : '0;
  assign o_index   = (state == STREAM) ? idx : '0;
  assign o_last    = (state == STREAM) & is_last;

endmodule

// File: tb/tb_acc_drain.sv
// Self-checking bench for acc_drain (NUM_PE = 4).
// The reference model works at transaction level: an accepted capture turns
// the sampled accumulators into a list of expected words pushed to a queue,
// and a counter of outstanding words tells whether the block should be busy.
// A negedge monitor pops and compares whenever a word is offered.

module tb_acc_drain;

  localparam int NUM_PE = 4;

  logic                  clock;
  logic                  reset;
  logic                  capture;
  logic                  i_int4_mode;
  logic [NUM_PE*20-1:0]  acc_in;
  logic                  clear_acc;
  logic                  busy;
  logic                  o_valid;
  logic                  i_ready;
  logic [19:0]           o_data;
  logic [4:0]            o_index;
  logic                  o_last;
  logic                  dropped;

  acc_drain #(.NUM_PE(NUM_PE)) dut (
    .clock       (clock),
    .reset       (reset),
    .capture     (capture),
    .i_int4_mode (i_int4_mode),
    .acc_in      (acc_in),
    .clear_acc   (clear_acc),
    .busy        (busy),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_data      (o_data),
    .o_index     (o_index),
    .o_last      (o_last),
    .dropped     (dropped)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    int data;
    int index;
    int last;
  } word_t;

  word_t exp_q[$];
  int    rem       = 0;
  int    exp_clear = 0;
  int    exp_drop  = 0;
  bit    started   = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int relu(input int v);
`ifdef ACC_DRAIN_RELU_EN
    return (v < 0) ? 0 : v;
`else
    return v;
`endif
  endfunction

  // Build the expected word list from the accumulators seen at the capture edge.
  task automatic push_snapshot(input logic [NUM_PE*20-1:0] acc, input logic int4);
    int n;
    int v;
    n = int4 ? 2 * NUM_PE : NUM_PE;
    for (int w = 0; w < n; w++) begin
      word_t e;
      if (!int4) begin
        v = int'(acc[20*w +: 20]);
        if (v >= 524288) v -= 1048576;
      end else begin
        v = int'(acc[20*(w/2) + 10*(w%2) +: 10]);
        if (v >= 512) v -= 1024;
      end
      e.data  = relu(v);
      e.index = w;
      e.last  = (w == n - 1) ? 1 : 0;
      exp_q.push_back(e);
    end
    rem = n;
  endtask

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_edge();
    if (!reset) begin
      exp_q.delete();
      rem       = 0;
      exp_clear = 0;
      exp_drop  = 0;
    end else begin
      exp_clear = 0;
      if (rem == 0) begin
        if (capture) begin
          push_snapshot(acc_in, i_int4_mode);
          exp_clear = 1;
        end
      end else begin
        if (capture) exp_drop = 1;
        if (i_ready) rem--;
      end
    end
  endtask

  // Apply inputs, let one edge pass, update the model, then move off the edge.
  task automatic step(input logic rst, input logic cap, input logic mode,
                      input logic rdy);
    reset       = rst;
    capture     = cap;
    i_int4_mode = mode;
    i_ready     = rdy;
    @(posedge clock);
    model_edge();
    started = 1'b1;
    #1;
  endtask

  // Monitor: compare on the falling edge, away from the active edge.
  always @(negedge clock) begin
    if (started) begin
      chk("busy",      int'(busy),      (rem > 0) ? 1 : 0);
      chk("o_valid",   int'(o_valid),   (rem > 0) ? 1 : 0);
      chk("clear_acc", int'(clear_acc), exp_clear);
      chk("dropped",   int'(dropped),   exp_drop);
      if (o_valid) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_word: got index %0d data %0d expected none", o_index, $signed(o_data));
        end else begin
          chk("o_data",  int'($signed(o_data)), exp_q[0].data);
          chk("o_index", int'(o_index),         exp_q[0].index);
          chk("o_last",  int'(o_last),          exp_q[0].last);
          if (i_ready) void'(exp_q.pop_front());
        end
      end else begin
        chk("idle_data",  int'(o_data),  0);
        chk("idle_index", int'(o_index), 0);
        chk("idle_last",  int'(o_last),  0);
      end
    end
  end

  function automatic logic [19:0] s20(input int v);
    logic [19:0] r;
    r = 20'(v);
    return r;
  endfunction

  initial begin
    int guard;
    reset       = 1'b0;
    capture     = 1'b0;
    i_int4_mode = 1'b0;
    i_ready     = 1'b0;
    acc_in      = '0;

    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1);

    // INT8 extremes, full-speed drain; acc_in changes after capture.
    acc_in = {s20(-524288), s20(524287), s20(-5), s20(100)};
    step(1'b1, 1'b1, 1'b0, 1'b1);
    acc_in = '1;
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0, 1'b1);

    // INT4 dual layout: PE0 high=-3, low=7.
    acc_in = {60'd0, 10'h3FD, 10'd7};
    step(1'b1, 1'b1, 1'b1, 1'b1);
    acc_in = '0;
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0, 1'b1);

    // Backpressure on word 1 for three cycles.
    acc_in = {s20(-524288), s20(524287), s20(-5), s20(100)};
    step(1'b1, 1'b1, 1'b0, 1'b1);   // capture edge
    step(1'b1, 1'b0, 1'b0, 1'b1);   // word 0 transfers
    step(1'b1, 1'b0, 1'b0, 1'b0);   // word 1 held
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 1'b1);

    // Captures on word 2 and on the last handshake are dropped,
    // capture in the following cycle is accepted.
    step(1'b1, 1'b1, 1'b0, 1'b1);   // capture edge
    step(1'b1, 1'b0, 1'b0, 1'b1);   // word 0
    step(1'b1, 1'b0, 1'b0, 1'b1);   // word 1
    step(1'b1, 1'b1, 1'b1, 1'b1);   // word 2 + ignored capture
    step(1'b1, 1'b1, 1'b1, 1'b1);   // word 3 (last) + ignored capture
    acc_in = {s20(7), s20(-8), s20(9), s20(-10)};
    step(1'b1, 1'b1, 1'b0, 1'b1);   // idle: accepted
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0, 1'b1);

    // Reset while word 2 is on the output.
    step(1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b1);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      for (int k = 0; k < NUM_PE; k++) acc_in[20*k +: 20] = 20'($urandom);
      step(($urandom_range(0, 499) != 0),
           ($urandom_range(0, 5) == 0),
           1'($urandom),
           ($urandom_range(0, 3) != 0));
    end

    // Drain whatever is outstanding, bounded.
    guard = 0;
    while (rem > 0 && guard < 100) begin
      step(1'b1, 1'b0, 1'b0, 1'b1);
      guard++;
    end
    step(1'b1, 1'b0, 1'b0, 1'b1);
    chk("drain_bound", (rem > 0) ? 1 : 0, 0);
    chk("queue_empty", exp_q.size(), 0);

    @(negedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/acc_drain.md
ACC_DRAIN -- requirements
Module: acc_drain

Interface
REQ-001 SHALL have parameter NUM_PE, default 4, meaning the number of MAC accumulators captured per snapshot (range 1..16).
REQ-002 SHALL have port clock  in  1  the single clock; all logic on its rising edge.
REQ-003 SHALL have port reset  in  1  synchronous, active-low reset (0 = reset asserted).
REQ-004 SHALL have port capture  in  1  snapshot request, acted on only in IDLE.
REQ-005 SHALL have port i_int4_mode  in  1  0 = INT8 layout, 1 = INT4 dual layout; sampled with capture.
REQ-006 SHALL have port acc_in  in  NUM_PE*20  packed signed accumulators; PE k occupies bits [20k+19:20k].
REQ-007 SHALL have port clear_acc  out  1  one-cycle pulse that clears the MAC array after a snapshot.
REQ-008 SHALL have port busy  out  1  high while a snapshot is held or streaming.
REQ-009 SHALL have port o_valid  out  1  output word valid.
REQ-010 SHALL have port i_ready  in  1  downstream ready.
REQ-011 SHALL have port o_data  out  20  signed output word.
REQ-012 SHALL have port o_index  out  5  index of the current word within the snapshot, starting at 0.
REQ-013 SHALL have port o_last  out  1  high with the final word of a snapshot.
REQ-014 SHALL have port dropped  out  1  sticky flag: a capture was ignored while busy.

Function
REQ-015 SHALL implement an FSM with states IDLE and STREAM.
REQ-016 IDLE with capture=1 SHALL latch every acc_in word and i_int4_mode into internal registers, then enter STREAM on the next cycle.
REQ-017 In the cycle after the capture edge, clear_acc SHALL be 1 for exactly one cycle, busy SHALL be 1, o_valid SHALL be 1 and word 0 SHALL be presented.
REQ-018 INT8 snapshot SHALL emit NUM_PE words in PE order 0..NUM_PE-1; each word is the 20-bit value unchanged.
REQ-019 INT4 snapshot SHALL emit 2*NUM_PE words: per PE, low half [9:0] first, then high half [19:10], each sign-extended to 20 bits.
REQ-020 A word SHALL transfer only when o_valid=1 and i_ready=1 at a clock edge; the next word, or IDLE after the last, SHALL follow on the next cycle.
REQ-021 While o_valid=1 and i_ready=0, o_data, o_index and o_last SHALL hold stable.
REQ-022 o_last SHALL be 1 only on index NUM_PE-1 (INT8) or 2*NUM_PE-1 (INT4).
REQ-023 After the last transfer the FSM SHALL return to IDLE; busy and o_valid SHALL be 0 in that next cycle.
REQ-024 capture=1 in any cycle with busy=1, including the cycle of the last handshake, SHALL be ignored and SHALL set dropped; the stream continues unaffected.
REQ-025 A capture in IDLE in the cycle directly after the last transfer SHALL be accepted normally; no dead cycles are required.
REQ-026 acc_in changes after the capture edge SHALL NOT affect the emitted words.
REQ-027 In IDLE, o_data and o_index SHALL be 0 and o_last SHALL be 0.

Reset
REQ-028 reset=0 at a clock edge SHALL force IDLE and clear the snapshot registers; clear_acc, busy, o_valid, o_last, o_data, o_index and dropped all go to 0.
REQ-029 reset mid-stream SHALL abandon the snapshot with no further words and no clear_acc pulse.
REQ-030 dropped SHALL clear only on reset.

Configuration
REQ-031 Macro ACC_DRAIN_RELU_EN defined: each emitted word SHALL be clamped to 0 when negative (after INT4 sign extension); non-negative words pass unchanged.
REQ-032 Macro ACC_DRAIN_RELU_EN undefined: words SHALL be emitted as signed values without clamping; no ReLU logic is present.

Verification (NUM_PE=4)
REQ-033 INT8, acc_in = {-524288, 524287, -5, 100} (PE3..PE0), capture pulse, i_ready=1 -> words 100, -5, 524287, -524288 on consecutive cycles, indices 0..3, o_last on index 3, a single clear_acc pulse in the first output cycle, busy low after.
REQ-034 INT4, PE0 = {high=-3, low=7}, other PEs 0 -> eight words; words 0,1 = 7, -3 (-3 = 20'hFFFFD); o_last on index 7.
REQ-035 Backpressure: i_ready=0 for 3 cycles on word 1 -> word 1 (value -5) held stable for all 4 cycles, no word skipped or duplicated.
REQ-036 capture asserted on word 2 and again in the last-handshake cycle -> both ignored, dropped=1, stream completes intact; a capture one cycle later is accepted.
REQ-037 reset=0 while on word 2 -> next cycle o_valid=0, busy=0, dropped=0, no clear_acc pulse.
REQ-038 With ACC_DRAIN_RELU_EN, REQ-033 stimulus -> words 100, 0, 524287, 0.
